rs_age_ordered: RTL

//  Parametrised reservation station: buffers decoded ALU ops until their operands resolve, then dispatches oldest-ready-first to the ALU.

---
 rtl/rs_age_ordered.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rs_age_ordered.sv
// Age-ordered reservation station: holds ALU ops until operands resolve, dispatches oldest-ready-first.
// Optional macro RS_BYPASS_WAKEUP_EN lets a slot woken by the CDB dispatch in the same cycle.
module rs_age_ordered #(
    parameter int RS_DEPTH  = 16,
    parameter int TAG_W     = 5,
    parameter int CDB_PORTS = 2,
    parameter int OP_W      = 6
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush_in,
    input  logic                         iss_valid_in,
    input  logic [OP_W-1:0]              iss_op_in,
    input  logic [31:0]                  iss_inst_in,
    input  logic [31:0]                  iss_pc_in,
    input  logic [31:0]                  iss_imm_in,
    input  logic [TAG_W-1:0]             iss_tag_in,
    input  logic [31:0]                  iss_vj_in,
    input  logic [31:0]                  iss_vk_in,
    input  logic [TAG_W-1:0]             iss_qj_in,
    input  logic [TAG_W-1:0]             iss_qk_in,
    output logic                         full_out,
    output logic [$clog2(RS_DEPTH+1)-1:0] occupancy_out,
    input  logic [CDB_PORTS-1:0]         cdb_valid_in,
    input  logic [CDB_PORTS*TAG_W-1:0]   cdb_tag_in,
    input  logic [CDB_PORTS*32-1:0]      cdb_value_in,
    output logic                         ex_valid_out,
    input  logic                         ex_ready_in,
    output logic [OP_W-1:0]              ex_op_out,
    output logic [31:0]                  ex_inst_out,
    output logic [31:0]                  ex_pc_out,
    output logic [31:0]                  ex_imm_out,
    output logic [31:0]                  ex_vj_out,
    output logic [31:0]                  ex_vk_out,
    output logic [TAG_W-1:0]             ex_tag_out
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = $clog2(RS_DEPTH+1);

    logic [RS_DEPTH-1:0] slot_valid;
    logic [OP_W-1:0]     slot_op   [RS_DEPTH];
    logic [31:0]         slot_inst [RS_DEPTH];
    logic [31:0]         slot_pc   [RS_DEPTH];
    logic [31:0]         slot_imm  [RS_DEPTH];
    logic [31:0]         slot_vj   [RS_DEPTH];
    logic [31:0]         slot_vk   [RS_DEPTH];
    logic [TAG_W-1:0]    slot_tag  [RS_DEPTH];
    logic [TAG_W-1:0]    slot_qj   [RS_DEPTH];
    logic [TAG_W-1:0]    slot_qk   [RS_DEPTH];
    // age[i][j] set means slot j is older than slot i
    logic [RS_DEPTH-1:0] age       [RS_DEPTH];

    logic [RS_DEPTH-1:0] j_hit, k_hit, cand;
    logic [31:0]         j_val [RS_DEPTH];
    logic [31:0]         k_val [RS_DEPTH];
    logic                iss_j_hit, iss_k_hit;
    logic [31:0]         iss_j_val, iss_k_val;
    logic                sel_found, free_found, load, issue_accept;
    logic [IDX_W-1:0]    sel_idx, free_idx;
    logic [CNT_W-1:0]    occ;

    // CDB snoop: ports scanned high to low so the lowest matching port overrides
    always_comb begin
        iss_j_hit = 1'b0;
        iss_k_hit = 1'b0;
        iss_j_val = iss_vj_in;
        iss_k_val = iss_vk_in;
        for (int i = 0; i < RS_DEPTH; i++) begin
            j_hit[i] = 1'b0;
            k_hit[i] = 1'b0;
            j_val[i] = slot_vj[i];
            k_val[i] = slot_vk[i];
        end
        for (int p = CDB_PORTS-1; p >= 0; p--) begin
            if (cdb_valid_in[p] && cdb_tag_in[p*TAG_W +: TAG_W] != '0) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (slot_valid[i] && slot_qj[i] == cdb_tag_in[p*TAG_W +: TAG_W]) begin
                        j_hit[i] = 1'b1;
                        j_val[i] = cdb_value_in[p*32 +: 32];
                    end
                    if (slot_valid[i] && slot_qk[i] == cdb_tag_in[p*TAG_W +: TAG_W]) begin
                        k_hit[i] = 1'b1;
                        k_val[i] = cdb_value_in[p*32 +: 32];
                    end
                end
                if (iss_qj_in == cdb_tag_in[p*TAG_W +: TAG_W]) begin
                    iss_j_hit = 1'b1;
                    iss_j_val = cdb_value_in[p*32 +: 32];
                end
                if (iss_qk_in == cdb_tag_in[p*TAG_W +: TAG_W]) begin
                    iss_k_hit = 1'b1;
                    iss_k_val = cdb_value_in[p*32 +: 32];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
`ifdef RS_BYPASS_WAKEUP_EN
            cand[i] = slot_valid[i] && (slot_qj[i] == '0 || j_hit[i]) && (slot_qk[i] == '0 || k_hit[i]);
`else
            cand[i] = slot_valid[i] && slot_qj[i] == '0 && slot_qk[i] == '0;
`endif
        end
    end

    // Oldest candidate wins; free slot is lowest index, occupancy from registered valid bits
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        occ        = '0;
        for (int i = RS_DEPTH-1; i >= 0; i--) begin
            if (cand[i] && (age[i] & cand) == '0) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!slot_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            occ = occ + CNT_W'(slot_valid[i]);
        end
    end

    assign full_out      = !free_found;
    assign occupancy_out = occ;
    assign load          = (!ex_valid_out || ex_ready_in) && sel_found;
    assign issue_accept  = iss_valid_in && free_found;

    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            slot_valid   <= '0;
            for (int i = 0; i < RS_DEPTH; i++) age[i] <= '0;
            ex_valid_out <= 1'b0;
            ex_op_out    <= '0;
            ex_inst_out  <= '0;
            ex_pc_out    <= '0;
            ex_imm_out   <= '0;
            ex_vj_out    <= '0;
            ex_vk_out    <= '0;
            ex_tag_out   <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (j_hit[i]) begin
                    slot_vj[i] <= j_val[i];
                    slot_qj[i] <= '0;
                end
                if (k_hit[i]) begin
                    slot_vk[i] <= k_val[i];
                    slot_qk[i] <= '0;
                end
            end
            if (load) begin
                ex_valid_out        <= 1'b1;
                ex_op_out           <= slot_op[sel_idx];
                ex_inst_out         <= slot_inst[sel_idx];
                ex_pc_out           <= slot_pc[sel_idx];
                ex_imm_out          <= slot_imm[sel_idx];
                ex_vj_out           <= j_val[sel_idx];
                ex_vk_out           <= k_val[sel_idx];
                ex_tag_out          <= slot_tag[sel_idx];
                slot_valid[sel_idx] <= 1'b0;
            end else if (ex_ready_in) begin
                ex_valid_out <= 1'b0;
            end
            // New entry is younger than every surviving slot; clear stale "older" marks pointing at it
            if (issue_accept) begin
                slot_valid[free_idx] <= 1'b1;
                slot_op[free_idx]    <= iss_op_in;
                slot_inst[free_idx]  <= iss_inst_in;
                slot_pc[free_idx]    <= iss_pc_in;
                slot_imm[free_idx]   <= iss_imm_in;
                slot_tag[free_idx]   <= iss_tag_in;
                slot_vj[free_idx]    <= iss_j_val;
                slot_vk[free_idx]    <= iss_k_val;
                slot_qj[free_idx]    <= iss_j_hit ? '0 : iss_qj_in;
                slot_qk[free_idx]    <= iss_k_hit ? '0 : iss_qk_in;
                for (int j = 0; j < RS_DEPTH; j++) begin
                    age[free_idx][j] <= slot_valid[j] && !(load && sel_idx == IDX_W'(j));
                    age[j][free_idx] <= 1'b0;
                end
            end
        end
    end
endmodule
